// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with load scoreboard.
// Holds the default geometry, the register index type and a ceiling-log2
// helper used to size the outstanding-load counter.
package regfile_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int ADDR_W_DEF = 4;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  // Smallest width w such that 2**w >= value (minimum 1 bit for value <= 2).
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    while ((32'sd1 << result) < value) begin
      result = result + 32'sd1;
    end
    if (result < 32'sd1) begin
      result = 32'sd1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle between the pipeline and the register file / scoreboard.
// master : pipeline side (drives read indices, write ports, load events)
// slave  : register file side (returns read data, Hazard, PendFull, ErrFlag)
// Signals: RS, RT, ReadRS, ReadRT, RegWrite, RD, WriteData, LoadIssue,
//          LoadIssueRD, LoadWrite, LoadRD, LoadData, Hazard, PendFull, ErrFlag.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] RS;
  logic [ADDR_W-1:0] RT;
  logic [DATA_W-1:0] ReadRS;
  logic [DATA_W-1:0] ReadRT;
  logic              RegWrite;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] WriteData;
  logic              LoadIssue;
  logic [ADDR_W-1:0] LoadIssueRD;
  logic              LoadWrite;
  logic [ADDR_W-1:0] LoadRD;
  logic [DATA_W-1:0] LoadData;
  logic              Hazard;
  logic              PendFull;
  logic              ErrFlag;

  modport master (
    output RS, RT, RegWrite, RD, WriteData,
    output LoadIssue, LoadIssueRD, LoadWrite, LoadRD, LoadData,
    input  ReadRS, ReadRT, Hazard, PendFull, ErrFlag
  );

  modport slave (
    input  RS, RT, RegWrite, RD, WriteData,
    input  LoadIssue, LoadIssueRD, LoadWrite, LoadRD, LoadData,
    output ReadRS, ReadRT, Hazard, PendFull, ErrFlag
  );

endinterface

// File: rtl/regfile_pend_counter.sv
// Up/down saturating counter of outstanding loads.
// Ports: clk, rst (async active-high), inc / dec (one-cycle requests),
//        full (count == MAX_PENDING), empty (count == 0, underflow guard).
// Requests that would overflow or underflow are ignored; the caller decides
// whether that is a protocol error.
module regfile_pend_counter
  import regfile_pkg::*;
#(
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = clog2(MAX_PENDING + 32'sd1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;

  // Limit flags decoded from the current count.
  always_comb begin
    full_s  = (count_r == CNT_MAX);
    empty_s = (count_r == {CNT_W{1'b0}});
  end

  // Count register: saturates at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && !full_s) begin
      count_r <= count_r + CNT_ONE;
    end else if (dec && !empty_s) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two combinational read ports, ALU and
// load writeback ports, and a per-register busy scoreboard that lets the
// in-order pipeline stall on RAW hazards against multi-cycle loads.
// Ports: Clock, Reset (async active-high), bus (regfile_scoreboard_if.slave).
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read
// forwarding (ALU over load) and for dropping Hazard on a register whose
// load data returns this cycle. Without it, writes are visible next cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int MAX_PENDING = 4,
  parameter int ZERO_REG    = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  regfile_scoreboard_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = clog2(MAX_PENDING + 32'sd1);
  localparam bit ZERO_EN  = (ZERO_REG != 32'sd0);

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [NUM_REGS-1:0] haz_busy_s;
  logic                err_r;
  logic                err_set_s;
  logic                alu_we_s;
  logic                load_we_s;
  logic                issue_v_s;
  logic                same_idx_s;
  logic                issue_drop_s;
  logic                issue_acc_s;
  logic                lw_bad_s;
  logic                issue_busy_s;
  logic                waw_s;
  logic                cnt_inc_s;
  logic                cnt_dec_s;
  logic                cnt_full_s;
  logic                cnt_empty_s;
  logic [DATA_W-1:0]   read_rs_s;
  logic [DATA_W-1:0]   read_rt_s;

  function automatic logic is_zero_idx(input logic [ADDR_W-1:0] idx);
    return ZERO_EN && (idx == {ADDR_W{1'b0}});
  endfunction

  // Write enables after the register-0 drop; ALU wins a same-index clash.
  always_comb begin
    alu_we_s  = bus.RegWrite & ~is_zero_idx(bus.RD);
    load_we_s = bus.LoadWrite & ~is_zero_idx(bus.LoadRD)
              & ~(alu_we_s & (bus.RD == bus.LoadRD));
  end

  // Register array; the load port is applied first so the ALU write dominates.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (load_we_s) begin
        regs_r[bus.LoadRD] <= bus.LoadData;
      end
      if (alu_we_s) begin
        regs_r[bus.RD] <= bus.WriteData;
      end
    end
  end

  // Scoreboard decisions for this cycle's issue / retire events.
  // An issue and a retire in the same cycle leave the count untouched; a
  // same-index pair means the new load supersedes the returning one.
  always_comb begin
    issue_v_s    = bus.LoadIssue & ~is_zero_idx(bus.LoadIssueRD);
    same_idx_s   = issue_v_s & bus.LoadWrite & (bus.LoadIssueRD == bus.LoadRD);
    issue_drop_s = issue_v_s & cnt_full_s & ~bus.LoadWrite;
    issue_acc_s  = issue_v_s & ~issue_drop_s;
    lw_bad_s     = bus.LoadWrite & (cnt_empty_s | ~busy_r[bus.LoadRD]);
    issue_busy_s = issue_acc_s & busy_r[bus.LoadIssueRD] & ~same_idx_s;
    waw_s        = bus.RegWrite & bus.LoadWrite & (bus.RD == bus.LoadRD);
    cnt_inc_s    = issue_acc_s & ~bus.LoadWrite;
    cnt_dec_s    = bus.LoadWrite & ~issue_v_s & ~lw_bad_s;
    err_set_s    = waw_s | issue_drop_s | lw_bad_s | issue_busy_s;
    busy_nxt_s   = busy_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_nxt_s[i] = (busy_r[i] & ~(bus.LoadWrite & (bus.LoadRD == ADDR_W'(i))))
                    | (issue_acc_s & (bus.LoadIssueRD == ADDR_W'(i)));
    end
  end

  // Busy vector register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Sticky protocol-violation flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

  regfile_pend_counter #(
    .MAX_PENDING (MAX_PENDING),
    .CNT_W       (CNT_W)
  ) u_pend_counter (
    .clk   (Clock),
    .rst   (Reset),
    .inc   (cnt_inc_s),
    .dec   (cnt_dec_s),
    .full  (cnt_full_s),
    .empty (cnt_empty_s)
  );

  // Busy bits as seen by the hazard check.
  always_comb begin
    haz_busy_s = busy_r;
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REGFILE_BYPASS_EN
      haz_busy_s[i] = busy_r[i] & ~(ZERO_EN && (i == 32'sd0))
                    & ~(bus.LoadWrite & (bus.LoadRD == ADDR_W'(i)));
`else
      haz_busy_s[i] = busy_r[i] & ~(ZERO_EN && (i == 32'sd0));
`endif
    end
  end

  // Read port RS. Forwarding is suppressed while Reset is held so reads stay 0.
  always_comb begin
    read_rs_s = regs_r[bus.RS];
    if (is_zero_idx(bus.RS)) begin
      read_rs_s = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (!Reset && bus.RegWrite && (bus.RD == bus.RS)) begin
      read_rs_s = bus.WriteData;
    end else if (!Reset && bus.LoadWrite && (bus.LoadRD == bus.RS)) begin
      read_rs_s = bus.LoadData;
`endif
    end else begin
      read_rs_s = regs_r[bus.RS];
    end
  end

  // Read port RT, same selection as RS.
  always_comb begin
    read_rt_s = regs_r[bus.RT];
    if (is_zero_idx(bus.RT)) begin
      read_rt_s = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (!Reset && bus.RegWrite && (bus.RD == bus.RT)) begin
      read_rt_s = bus.WriteData;
    end else if (!Reset && bus.LoadWrite && (bus.LoadRD == bus.RT)) begin
      read_rt_s = bus.LoadData;
`endif
    end else begin
      read_rt_s = regs_r[bus.RT];
    end
  end

  assign bus.ReadRS   = read_rs_s;
  assign bus.ReadRT   = read_rt_s;
  assign bus.Hazard   = haz_busy_s[bus.RS] | haz_busy_s[bus.RT];
  assign bus.PendFull = cnt_full_s;
  assign bus.ErrFlag  = err_r;

endmodule
